// File: rtl/bus_pkg.sv
// Shared definitions for the 8-slot system bus: device IDs, control bits,
// address-map fields, arbiter states and the fixed-priority pick.
package bus_pkg;

    localparam int unsigned D_WIDTH     = 32;
    localparam int unsigned C_WIDTH     = 8;
    localparam int unsigned NUM_DEVICES = 8;
    localparam int unsigned ID_W        = 3;

    localparam logic [ID_W-1:0] RAM_BUS_ID   = 3'd0;
    localparam logic [ID_W-1:0] ROM_BUS_ID   = 3'd1;
    localparam logic [ID_W-1:0] VGA_BUS_ID   = 3'd2;
    localparam logic [ID_W-1:0] PS2_BUS_ID   = 3'd3;
    localparam logic [ID_W-1:0] ACP_BUS_ID   = 3'd4;
    localparam logic [ID_W-1:0] SPARE_BUS_ID = 3'd5;
    localparam logic [ID_W-1:0] UART_BUS_ID  = 3'd6;
    localparam logic [ID_W-1:0] CPU_BUS_ID   = 3'd7;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_WRITE = 1;

    // Address layout: [31:27] must be zero, [26:24] carry the target ID.
    localparam int unsigned ADDR_ID_LSB   = 24;
    localparam int unsigned ADDR_ID_MSB   = 26;
    localparam int unsigned ADDR_ZERO_LSB = 27;
    localparam int unsigned ADDR_TOP_W    = D_WIDTH - ADDR_ID_LSB;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        XFER
    } bus_state_e;

    // Highest set request bit wins.
    function automatic logic [ID_W-1:0] highest_req(input logic [NUM_DEVICES-1:0] r);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < int'(NUM_DEVICES); i++) begin
            if (r[i]) id = ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/bus_address_translator.sv
// Single source of the bus address map: top address byte -> {valid, slave ID}.
module bus_address_translator
    import bus_pkg::*;
(
    input  logic [ADDR_TOP_W-1:0] addr_top,
    output logic                  valid,
    output logic [ID_W-1:0]       id
);

    assign id = addr_top[ADDR_ID_MSB-ADDR_ID_LSB:0];

    // The spare slot has no slave behind it, so it decodes as unmapped.
    assign valid = (addr_top[ADDR_TOP_W-1:ADDR_ZERO_LSB-ADDR_ID_LSB] == '0) &&
                   (id != SPARE_BUS_ID);

endmodule

// File: rtl/bus_controller.sv
// Arbiter and data/control crossbar for the 8-slot system bus.
// Define BUS_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module bus_controller
    import bus_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DEVICES-1:0] req,
    output logic [NUM_DEVICES-1:0] ack,
    input  logic [D_WIDTH-1:0]     bus_in_0,
    input  logic [D_WIDTH-1:0]     bus_in_1,
    input  logic [D_WIDTH-1:0]     bus_in_2,
    input  logic [D_WIDTH-1:0]     bus_in_3,
    input  logic [D_WIDTH-1:0]     bus_in_4,
    input  logic [D_WIDTH-1:0]     bus_in_5,
    input  logic [D_WIDTH-1:0]     bus_in_6,
    input  logic [D_WIDTH-1:0]     bus_in_7,
    input  logic [C_WIDTH-1:0]     ctrl_in_0,
    input  logic [C_WIDTH-1:0]     ctrl_in_1,
    input  logic [C_WIDTH-1:0]     ctrl_in_2,
    input  logic [C_WIDTH-1:0]     ctrl_in_3,
    input  logic [C_WIDTH-1:0]     ctrl_in_4,
    input  logic [C_WIDTH-1:0]     ctrl_in_5,
    input  logic [C_WIDTH-1:0]     ctrl_in_6,
    input  logic [C_WIDTH-1:0]     ctrl_in_7,
    output logic [D_WIDTH-1:0]     bus_out,
    output logic [C_WIDTH-1:0]     ctrl_out
);

    logic [D_WIDTH-1:0] bus_arr  [NUM_DEVICES];
    logic [C_WIDTH-1:0] ctrl_arr [NUM_DEVICES];

    bus_state_e            state;
    logic [ID_W-1:0]       master;
    logic [ID_W-1:0]       winner;
    logic [ADDR_TOP_W-1:0] master_addr_top;
    logic                  addr_valid;
    logic [ID_W-1:0]       addr_id;

    assign bus_arr  = '{bus_in_0, bus_in_1, bus_in_2, bus_in_3,
                        bus_in_4, bus_in_5, bus_in_6, bus_in_7};
    assign ctrl_arr = '{ctrl_in_0, ctrl_in_1, ctrl_in_2, ctrl_in_3,
                        ctrl_in_4, ctrl_in_5, ctrl_in_6, ctrl_in_7};

    assign master_addr_top = bus_arr[master][D_WIDTH-1:ADDR_ID_LSB];

    bus_address_translator u_addr_xlat (
        .addr_top (master_addr_top),
        .valid    (addr_valid),
        .id       (addr_id)
    );

`ifdef BUS_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    // Search upward from the slot after the last granted master.
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= int'(NUM_DEVICES); k++) begin
            idx = rr_ptr + ID_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`else
    assign winner = highest_req(req);
`endif

    // Arbiter FSM; ack is the registered grant/select vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ack    <= '0;
            master <= '0;
`ifdef BUS_ROUND_ROBIN_EN
            rr_ptr <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        master <= winner;
                        ack    <= NUM_DEVICES'(1) << winner;
                        state  <= GRANT;
`ifdef BUS_ROUND_ROBIN_EN
                        rr_ptr <= winner;
`endif
                    end
                end
                GRANT: begin
                    // Release takes precedence over a coincident START.
                    if (!req[master]) begin
                        ack   <= '0;
                        state <= IDLE;
                    end else if (ctrl_arr[master][CTRL_START] && addr_valid &&
                                 (addr_id != master)) begin
                        ack[addr_id] <= 1'b1;
                        state        <= XFER;
                    end
                end
                XFER: begin
                    if (!req[master]) begin
                        ack   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Shared bus is the OR of every acknowledged device's outputs.
    always_comb begin
        bus_out  = '0;
        ctrl_out = '0;
        for (int i = 0; i < int'(NUM_DEVICES); i++) begin
            if (ack[i]) begin
                bus_out  = bus_out | bus_arr[i];
                ctrl_out = ctrl_out | ctrl_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_bus_controller.sv
// Directed self-checking bench for bus_controller; expectations follow
// BUS_ROUND_ROBIN_EN when it is defined.
module tb_bus_controller;

    logic        clk50MHz;
    logic        reset;
    logic [7:0]  req;
    logic [7:0]  ack;
    logic [31:0] bi [8];
    logic [7:0]  ci [8];
    logic [31:0] bus_out;
    logic [7:0]  ctrl_out;

    int total;
    int bad;

    bus_controller dut (
        .clk       (clk50MHz),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .bus_in_0  (bi[0]),
        .bus_in_1  (bi[1]),
        .bus_in_2  (bi[2]),
        .bus_in_3  (bi[3]),
        .bus_in_4  (bi[4]),
        .bus_in_5  (bi[5]),
        .bus_in_6  (bi[6]),
        .bus_in_7  (bi[7]),
        .ctrl_in_0 (ci[0]),
        .ctrl_in_1 (ci[1]),
        .ctrl_in_2 (ci[2]),
        .ctrl_in_3 (ci[3]),
        .ctrl_in_4 (ci[4]),
        .ctrl_in_5 (ci[5]),
        .ctrl_in_6 (ci[6]),
        .ctrl_in_7 (ci[7]),
        .bus_out   (bus_out),
        .ctrl_out  (ctrl_out)
    );

    initial clk50MHz = 1'b0;
    always #5 clk50MHz = ~clk50MHz;

    task automatic tick();
        @(posedge clk50MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 8; i++) begin
            bi[i] = '0;
            ci[i] = '0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req   = '0;
        clear_inputs();
        for (int i = 0; i < 8; i++) bi[i] = 32'h1111_1111 * (i + 1);
        tick();
        tick();
        reset = 1'b0;
        chk("reset_ack", 32'(ack), 32'h00);
        chk("reset_bus", bus_out, 32'h0);
        chk("reset_ctrl", 32'(ctrl_out), 32'h00);

        // Single CPU master targeting PS2.
        clear_inputs();
        req = 8'h80;
        tick();
        chk("cpu_grant", 32'(ack), 32'h80);
        bi[7] = 32'h0300_0000;
        ci[7] = 8'h01;
        bi[3] = 32'h0000_1234;
        ci[3] = 8'h04;
        #1;
        chk("cpu_bus_only", bus_out, 32'h0300_0000);
        tick();
        chk("cpu_ps2_ack", 32'(ack), 32'h88);
        chk("cpu_ps2_bus", bus_out, 32'h0300_1234);
        chk("cpu_ps2_ctrl", 32'(ctrl_out), 32'h05);

        // CPU releases while UART waits.
        req   = 8'h40;
        ci[7] = 8'h00;
        tick();
        chk("release_ack", 32'(ack), 32'h00);
        chk("release_bus", bus_out, 32'h0);
        tick();
        chk("uart_grant", 32'(ack), 32'h40);

        // Unmapped and self-addressed targets never add a slave bit.
        ci[6] = 8'h01;
        bi[6] = 32'h0800_0000;
        tick();
        chk("unmapped_hi", 32'(ack), 32'h40);
        bi[6] = 32'h0500_0000;
        tick();
        chk("unmapped_spare", 32'(ack), 32'h40);
        bi[6] = 32'h0600_0000;
        tick();
        chk("self_addr", 32'(ack), 32'h40);

        // UART to RAM, then data merge with non-acked devices all ones.
        bi[6] = 32'h0000_0010;
        tick();
        chk("uart_ram_ack", 32'(ack), 32'h41);
        for (int i = 0; i < 8; i++) begin
            bi[i] = 32'hFFFF_FFFF;
            ci[i] = 8'hFF;
        end
        bi[6] = 32'h0000_00A5;
        bi[0] = 32'h0000_5A00;
        ci[6] = 8'h01;
        ci[0] = 8'h00;
        #1;
        chk("merge_bus", bus_out, 32'h0000_5AA5);
        chk("merge_ctrl", 32'(ctrl_out), 32'h01);

        clear_inputs();
        req = 8'h00;
        tick();
        chk("uart_release", 32'(ack), 32'h00);
        tick();
        chk("idle_hold", 32'(ack), 32'h00);

        // Contention after a UART tenure: both modes give the CPU.
        req = 8'hC0;
        tick();
        chk("contend_1", 32'(ack), 32'h80);
        req = 8'h00;
        tick();
        tick();
        // Contention after a CPU tenure.
        req = 8'hC0;
        tick();
`ifdef BUS_ROUND_ROBIN_EN
        chk("contend_2", 32'(ack), 32'h40);
`else
        chk("contend_2", 32'(ack), 32'h80);
`endif

        // Whichever master won targets RAM; reset mid-transfer.
        ci[6] = 8'h01;
        ci[7] = 8'h01;
        bi[0] = 32'h0000_BEEF;
        tick();
`ifdef BUS_ROUND_ROBIN_EN
        chk("xfer_ack", 32'(ack), 32'h41);
`else
        chk("xfer_ack", 32'(ack), 32'h81);
`endif
        reset = 1'b1;
        tick();
        chk("midreset_ack", 32'(ack), 32'h00);
        chk("midreset_bus", bus_out, 32'h0);
        reset = 1'b0;
        req   = 8'h00;
        clear_inputs();
        tick();
        chk("post_reset_idle", 32'(ack), 32'h00);

        // Release coincident with START in GRANT: no slave is acked.
        req = 8'h08;
        tick();
        chk("ps2_grant", 32'(ack), 32'h08);
        req   = 8'h00;
        ci[3] = 8'h01;
        tick();
        chk("release_wins", 32'(ack), 32'h00);
        tick();
        chk("stay_idle", 32'(ack), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
